// File: rtl/banner_scroll_streamer_pkg.sv
// Shared definitions for the banner scroll streamer: FSM encoding and default banner geometry.
package banner_scroll_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 57;
    localparam int DEF_ROWS     = 43;
    localparam int DEF_VSCALE   = 3;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_OROW_W   = 8;
    localparam int DEF_SCROLL_W = 6;

endpackage

// File: rtl/banner_scroll_streamer_rom.sv
// Block-ROM style banner store with a registered read; rows beyond the image read as zero.
module banner_rom #(
   parameter int                     WIDTH     = 57,
   parameter int                     ROWS      = 43,
   parameter int                     ADDR_W    = 8,
   parameter                         INIT_FILE = "banner.mem",
   parameter logic [WIDTH*ROWS-1:0]  INIT_DATA = '0
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [WIDTH-1:0]  data
);

   logic [WIDTH-1:0] mem [2**ADDR_W];
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   // The image is taken from INIT_DATA, packed with row 0 in the low bits; unused rows are zero.
   for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_row
      if (i < ROWS) begin : g_used
         assign mem[i] = INIT_DATA[i*WIDTH +: WIDTH];
      end else begin : g_unused
         assign mem[i] = '0;
      end
   end

   // Addresses at or beyond ROWS read as zero before the output register.
   always_comb begin
      data_d = '0;
      if ({1'b0, addr} < (ADDR_W + 1)'(ROWS)) begin
         data_d = mem[addr];
      end
   end

   // Registered read, so data appears the cycle after the address is presented.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/banner_scroll_streamer.sv
// Streams a stored banner one row per beat, repeating rows VSCALE times and rotating each
// row left by a scroll offset that advances once per completed frame.
module banner_scroll_streamer
    import banner_scroll_streamer_pkg::*;
#(
    parameter int                     WIDTH     = DEF_WIDTH,
    parameter int                     ROWS      = DEF_ROWS,
    parameter int                     VSCALE    = DEF_VSCALE,
    parameter int                     ADDR_W    = DEF_ADDR_W,
    parameter int                     OROW_W    = DEF_OROW_W,
    parameter int                     SCROLL_W  = DEF_SCROLL_W,
    parameter                         INIT_FILE = "banner.mem",
    parameter logic [WIDTH*ROWS-1:0]  INIT_DATA = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                scroll_en,
    input  logic [SCROLL_W-1:0] scroll_step,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [OROW_W-1:0]   out_row,
    output logic                out_last,
    output logic                frame_done,
    output logic [SCROLL_W-1:0] offset
);

    localparam int REP_W = (VSCALE > 1) ? $clog2(VSCALE) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic [OROW_W-1:0]   out_row_q, out_row_d;
    logic                frame_done_q, frame_done_d;
    logic [SCROLL_W-1:0] offset_q, offset_d;

    logic [WIDTH-1:0]    rom_data;
    logic [2*WIDTH-1:0]  rot_dbl;
    logic [WIDTH-1:0]    rot_data;
    logic [SCROLL_W:0]   offset_sum;
    logic [SCROLL_W-1:0] offset_next;
    logic                row_is_last;
    logic                rep_is_last;

    banner_rom #(
        .WIDTH     (WIDTH),
        .ROWS      (ROWS),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE),
        .INIT_DATA (INIT_DATA)
    ) u_rom (
        .clk  (clk),
        .addr (row_q),
        .data (rom_data)
    );

    assign row_is_last = (row_q == ADDR_W'(ROWS - 1));
    assign rep_is_last = (rep_q == REP_W'(VSCALE - 1));

    // Rotating the doubled word and keeping its top half gives rotl without a WIDTH-offset term.
    always_comb begin
        rot_dbl  = '0;
        rot_dbl  = {rom_data, rom_data} << offset_q;
        rot_data = rot_dbl[2*WIDTH-1 -: WIDTH];
    end

    always_comb begin
        offset_sum = {1'b0, offset_q};
        if ({1'b0, scroll_step} < (SCROLL_W + 1)'(WIDTH)) begin
            offset_sum = {1'b0, offset_q} + {1'b0, scroll_step};
        end
        offset_next = offset_sum[SCROLL_W-1:0];
        if (offset_sum >= (SCROLL_W + 1)'(WIDTH)) begin
            offset_next = SCROLL_W'(offset_sum - (SCROLL_W + 1)'(WIDTH));
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        rep_d        = rep_q;
        out_row_d    = out_row_q;
        frame_done_d = 1'b0;
        offset_d     = offset_q;
        case (state_q)
            IDLE: begin
                if (start && !frame_done_q) begin
                    row_d     = '0;
                    rep_d     = '0;
                    out_row_d = '0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                state_d = VALID;
            end
            VALID: begin
                if (out_ready) begin
                    if (!rep_is_last) begin
                        rep_d     = rep_q + REP_W'(1);
                        out_row_d = out_row_q + OROW_W'(1);
                    end else if (!row_is_last) begin
                        rep_d     = '0;
                        row_d     = row_q + ADDR_W'(1);
                        out_row_d = out_row_q + OROW_W'(1);
                        state_d   = FETCH;
                    end else begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        if (scroll_en) begin
                            offset_d = offset_next;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            rep_q        <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
            offset_q     <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            rep_q        <= rep_d;
            out_row_q    <= out_row_d;
            frame_done_q <= frame_done_d;
            offset_q     <= offset_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == VALID);
    assign out_last   = out_valid && row_is_last && rep_is_last;
    assign out_data   = out_valid ? rot_data : '0;
    assign out_row    = out_row_q;
    assign frame_done = frame_done_q;
    assign offset     = offset_q;

endmodule
